// File: rtl/result_bus_arbiter_pkg.sv
// Shared constants for the ROB result-bus arbiter: widths and producer ids.
package result_bus_arbiter_pkg;

    localparam int unsigned ROB_WIDTH = 4;
    localparam int unsigned N_SRC     = 3;

    localparam int unsigned SRC_ALU   = 0;
    localparam int unsigned SRC_LOAD  = 1;
    localparam int unsigned SRC_STORE = 2;

    localparam int unsigned SRC_ID_W  = 2;
    typedef logic [SRC_ID_W-1:0] src_id_t;

endpackage

// File: rtl/result_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping at N.
module rr_picker
    import result_bus_arbiter_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] winner_o,
    output logic             any_o
);

    localparam int unsigned DW = $clog2(2 * N);

    logic [2*N-1:0] dbl;
    logic [DW-1:0]  idx;
    logic [DW-1:0]  wrapped;

    // Searching the doubled vector turns the modulo wrap into a plain upward scan.
    assign dbl = {req_i, req_i};

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = '0;
        wrapped  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = DW'(ptr_i) + DW'(k);
            if (!any_o && dbl[idx]) begin
                any_o    = 1'b1;
                wrapped  = (idx >= DW'(N)) ? (idx - DW'(N)) : idx;
                winner_o = PTR_W'(wrapped);
            end
        end
        if (any_o) begin
            gnt_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Shares the registered ROB result bus among N_SRC producers, each with a one-entry slot.
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = result_bus_arbiter_pkg::ROB_WIDTH,
    parameter int unsigned N_SRC     = result_bus_arbiter_pkg::N_SRC
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      clear,
    input  logic [N_SRC-1:0]          srcValid,
    input  logic [N_SRC*ROB_WIDTH-1:0] srcRobIndex,
    input  logic [N_SRC*32-1:0]       srcValue,
    output logic [N_SRC-1:0]          srcReady,
    output logic                      busValid,
    output logic [ROB_WIDTH-1:0]      busRobIndex,
    output logic [31:0]               busValue,
    output logic [1:0]                busSrc
);

    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]     held_q, held_d;
    logic [ROB_WIDTH-1:0] slot_idx_q [N_SRC];
    logic [ROB_WIDTH-1:0] slot_idx_d [N_SRC];
    logic [31:0]          slot_val_q [N_SRC];
    logic [31:0]          slot_val_d [N_SRC];
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 bus_valid_q, bus_valid_d;
    logic [ROB_WIDTH-1:0] bus_idx_q, bus_idx_d;
    logic [31:0]          bus_val_q, bus_val_d;
    src_id_t              bus_src_q, bus_src_d;

    logic [N_SRC-1:0]     grant;
    logic [PTR_W-1:0]     winner;
    logic                 any_grant;
    logic [N_SRC-1:0]     accept;

    rr_picker #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req_i    (held_q),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (grant),
        .winner_o (winner),
        .any_o    (any_grant)
    );

    // A slot being drained this cycle may be refilled at the same edge.
    assign srcReady = clear ? '0 : (~held_q | grant);
    assign accept   = srcValid & srcReady;

    always_comb begin
        held_d      = held_q;
        slot_idx_d  = slot_idx_q;
        slot_val_d  = slot_val_q;
        rr_ptr_d    = rr_ptr_q;
        bus_valid_d = 1'b0;
        bus_idx_d   = bus_idx_q;
        bus_val_d   = bus_val_q;
        bus_src_d   = bus_src_q;

        for (int i = 0; i < int'(N_SRC); i++) begin
            if (grant[i]) begin
                held_d[i] = 1'b0;
            end
            if (accept[i]) begin
                held_d[i]     = 1'b1;
                slot_idx_d[i] = srcRobIndex[i*ROB_WIDTH +: ROB_WIDTH];
                slot_val_d[i] = srcValue[i*32 +: 32];
            end
        end

        if (clear) begin
            held_d = '0;
        end else if (any_grant) begin
            bus_valid_d = 1'b1;
            bus_idx_d   = slot_idx_q[winner];
            bus_val_d   = slot_val_q[winner];
            bus_src_d   = src_id_t'(winner);
            rr_ptr_d    = (winner == PTR_W'(N_SRC - 1)) ? '0 : (winner + PTR_W'(1));
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            held_q      <= '0;
            rr_ptr_q    <= '0;
            bus_valid_q <= 1'b0;
            bus_idx_q   <= '0;
            bus_val_q   <= '0;
            bus_src_q   <= '0;
            for (int i = 0; i < int'(N_SRC); i++) begin
                slot_idx_q[i] <= '0;
                slot_val_q[i] <= '0;
            end
        end else begin
            held_q      <= held_d;
            rr_ptr_q    <= rr_ptr_d;
            bus_valid_q <= bus_valid_d;
            bus_idx_q   <= bus_idx_d;
            bus_val_q   <= bus_val_d;
            bus_src_q   <= bus_src_d;
            slot_idx_q  <= slot_idx_d;
            slot_val_q  <= slot_val_d;
        end
    end

    assign busValid    = bus_valid_q;
    assign busRobIndex = bus_idx_q;
    assign busValue    = bus_val_q;
    assign busSrc      = bus_src_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: vector table plus scoreboarded multi-cycle sequences.
module tb_result_bus_arbiter;

    localparam int RW = 4;
    localparam int NS = 3;

    logic             clockIn = 1'b0;
    logic             resetIn;
    logic             clear;
    logic [NS-1:0]    srcValid;
    logic [NS*RW-1:0] srcRobIndex;
    logic [NS*32-1:0] srcValue;
    logic [NS-1:0]    srcReady;
    logic             busValid;
    logic [RW-1:0]    busRobIndex;
    logic [31:0]      busValue;
    logic [1:0]       busSrc;

    result_bus_arbiter #(
        .ROB_WIDTH (RW),
        .N_SRC     (NS)
    ) dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .clear       (clear),
        .srcValid    (srcValid),
        .srcRobIndex (srcRobIndex),
        .srcValue    (srcValue),
        .srcReady    (srcReady),
        .busValid    (busValid),
        .busRobIndex (busRobIndex),
        .busValue    (busValue),
        .busSrc      (busSrc)
    );

    always #5 clockIn = ~clockIn;

    typedef struct {
        logic [1:0]  src;
        logic [3:0]  idx;
        logic [31:0] val;
    } res_t;

    typedef struct {
        int          src;
        logic [3:0]  idx;
        logic [31:0] val;
        logic [1:0]  exp_src;
        logic [3:0]  exp_idx;
        logic [31:0] exp_val;
    } vec_t;

    res_t        sb[$];
    vec_t        vecs[4];
    int          checks;
    int          errors;
    int          cycle;
    int          pulses;
    int          first_v;
    int          last_v;
    logic [NS-1:0] last_acc;
    logic [NS-1:0] last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock: capture handshake before the edge, then check any bus pulse against the scoreboard.
    task automatic step();
        res_t e;
        #1;
        last_rdy = srcReady;
        last_acc = srcValid & srcReady;
        @(posedge clockIn);
        #1;
        cycle++;
        if (busValid) begin
            pulses++;
            if (first_v < 0) first_v = cycle;
            last_v = cycle;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected actual src=%0d idx=%0h val=%h required no result",
                         busSrc, busRobIndex, busValue);
            end else begin
                e = sb.pop_front();
                chk("bus_src", 64'(busSrc), 64'(e.src));
                chk("bus_idx", 64'(busRobIndex), 64'(e.idx));
                chk("bus_val", 64'(busValue), 64'(e.val));
            end
        end
    endtask

    task automatic drive(input int s, input logic [3:0] idx, input logic [31:0] val,
                         input bit push);
        srcValid[s]             = 1'b1;
        srcRobIndex[s*RW +: RW] = idx;
        srcValue[s*32 +: 32]    = val;
        if (push) sb.push_back('{2'(s), idx, val});
    endtask

    task automatic push_exp(input int s, input logic [3:0] idx, input logic [31:0] val);
        sb.push_back('{2'(s), idx, val});
    endtask

    task automatic drop_accepted();
        srcValid = srcValid & ~last_acc;
    endtask

    task automatic clr_pulses();
        pulses  = 0;
        first_v = -1;
        last_v  = -1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int na;
        int nb;
        checks      = 0;
        errors      = 0;
        cycle       = 0;
        resetIn     = 1'b0;
        clear       = 1'b0;
        srcValid    = '0;
        srcRobIndex = '0;
        srcValue    = '0;
        clr_pulses();

        vecs[0] = '{1, 4'h5, 32'hDEADBEEF, 2'd1, 4'h5, 32'hDEADBEEF};
        vecs[1] = '{0, 4'h3, 32'h12345678, 2'd0, 4'h3, 32'h12345678};
        vecs[2] = '{1, 4'h0, 32'h00000000, 2'd1, 4'h0, 32'h00000000};
        vecs[3] = '{2, 4'hF, 32'hFFFFFFFF, 2'd2, 4'hF, 32'hFFFFFFFF};

        // Reset state
        repeat (2) @(posedge clockIn);
        #1;
        chk("rst_bus_valid", 64'(busValid), 64'(0));
        chk("rst_bus_idx", 64'(busRobIndex), 64'(0));
        chk("rst_bus_val", 64'(busValue), 64'(0));
        chk("rst_bus_src", 64'(busSrc), 64'(0));
        resetIn = 1'b1;
        #1;
        chk("rst_src_ready", 64'(srcReady), 64'(3'b111));

        // Single offers: exact two-cycle latency, one-cycle pulse; leaves rrPtr at 0
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k].src, vecs[k].idx, vecs[k].val, 1'b0);
            push_exp(int'(vecs[k].exp_src), vecs[k].exp_idx, vecs[k].exp_val);
            chk("lat_t0", 64'(busValid), 64'(0));
            step();
            chk("single_accept", 64'(last_acc[vecs[k].src]), 64'(1));
            drop_accepted();
            chk("lat_t1", 64'(busValid), 64'(0));
            step();
            chk("lat_t2", 64'(busValid), 64'(1));
            step();
            chk("lat_t3", 64'(busValid), 64'(0));
        end
        chk("single_sb_empty", 64'(sb.size()), 64'(0));

        // Three-way contention from rrPtr=0
        clr_pulses();
        drive(0, 4'h1, 32'hA0000001, 1'b1);
        drive(1, 4'h2, 32'hB0000002, 1'b1);
        drive(2, 4'h3, 32'hC0000003, 1'b1);
        step();
        chk("3way_accept", 64'(last_acc), 64'(3'b111));
        drop_accepted();
        drain("3way_drain", 10);
        chk("3way_pulses", 64'(pulses), 64'(3));
        chk("3way_b2b", 64'(last_v - first_v), 64'(2));
        step();
        chk("3way_idle", 64'(busValid), 64'(0));

        // Fairness: src0 and src2 stream continuously, grants must alternate 0,2,0,2...
        clr_pulses();
        for (int k = 0; k < 4; k++) begin
            push_exp(0, 4'(k), 32'hA0A00000 + 32'(k));
            push_exp(2, 4'(8 + k), 32'hC2C20000 + 32'(k));
        end
        na = 0;
        nb = 0;
        for (int c = 0; c < 40 && (na < 4 || nb < 4); c++) begin
            if (!srcValid[0] && na < 4) drive(0, 4'(na), 32'hA0A00000 + 32'(na), 1'b0);
            if (!srcValid[2] && nb < 4) drive(2, 4'(8 + nb), 32'hC2C20000 + 32'(nb), 1'b0);
            step();
            if (last_acc[0]) na++;
            if (last_acc[2]) nb++;
            drop_accepted();
        end
        chk("fair_sent0", 64'(na), 64'(4));
        chk("fair_sent2", 64'(nb), 64'(4));
        drain("fair_drain", 10);
        chk("fair_pulses", 64'(pulses), 64'(8));
        chk("fair_b2b", 64'(last_v - first_v), 64'(7));

        // rrPtr must have wrapped back to 0: src0 beats src1
        clr_pulses();
        drive(1, 4'h7, 32'h11110007, 1'b0);
        drive(0, 4'h6, 32'h00000006, 1'b0);
        push_exp(0, 4'h6, 32'h00000006);
        push_exp(1, 4'h7, 32'h11110007);
        step();
        drop_accepted();
        drain("wrap_drain", 10);
        chk("wrap_pulses", 64'(pulses), 64'(2));

        // Streaming: src0 alone, one result per cycle
        clr_pulses();
        for (int k = 0; k < 8; k++) push_exp(0, 4'(k), 32'h50000000 + 32'(k));
        for (int k = 0; k < 8; k++) begin
            drive(0, 4'(k), 32'h50000000 + 32'(k), 1'b0);
            step();
            chk("stream_ready", 64'(last_rdy[0]), 64'(1));
            drop_accepted();
        end
        drain("stream_drain", 10);
        chk("stream_pulses", 64'(pulses), 64'(8));
        chk("stream_b2b", 64'(last_v - first_v), 64'(7));

        // Clear with slots 0 and 2 held and the bus busy (rrPtr=1 here, so src1 goes first)
        clr_pulses();
        drive(0, 4'hA, 32'hBAD00000, 1'b0);
        drive(1, 4'hB, 32'h0000C1EA, 1'b1);
        drive(2, 4'hC, 32'hBAD00002, 1'b0);
        step();
        chk("clear_setup_accept", 64'(last_acc), 64'(3'b111));
        drop_accepted();
        step();
        chk("clear_bus_before", 64'(busValid), 64'(1));
        clear = 1'b1;
        drive(1, 4'h9, 32'hBAD00001, 1'b0);
        #1;
        chk("clear_ready", 64'(srcReady), 64'(0));
        step();
        clear    = 1'b0;
        srcValid = '0;
        chk("clear_bus_drop", 64'(busValid), 64'(0));
        step();
        step();
        chk("clear_no_stale", 64'(pulses), 64'(1));
        drive(2, 4'h6, 32'h600DF00D, 1'b1);
        chk("post_clear_t0", 64'(busValid), 64'(0));
        step();
        drop_accepted();
        chk("post_clear_t1", 64'(busValid), 64'(0));
        step();
        chk("post_clear_t2", 64'(busValid), 64'(1));
        step();
        chk("post_clear_t3", 64'(busValid), 64'(0));

        // Asynchronous reset between edges while slots are held
        clr_pulses();
        drive(0, 4'h1, 32'hE0000000, 1'b1);
        drive(1, 4'h2, 32'hE0000001, 1'b0);
        drive(2, 4'h3, 32'hE0000002, 1'b0);
        step();
        drop_accepted();
        step();
        chk("arst_bus_before", 64'(busValid), 64'(1));
        #2;
        resetIn = 1'b0;
        #1;
        chk("arst_bus_valid", 64'(busValid), 64'(0));
        chk("arst_bus_idx", 64'(busRobIndex), 64'(0));
        chk("arst_bus_val", 64'(busValue), 64'(0));
        chk("arst_bus_src", 64'(busSrc), 64'(0));
        chk("arst_src_ready", 64'(srcReady), 64'(3'b111));
        #2;
        resetIn = 1'b1;
        repeat (5) step();
        chk("arst_no_stale", 64'(pulses), 64'(1));
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
